// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
//  Request and response channels between the EX stage / writeback and the
//  load/store sequencer.
//  Ports (signals):
//   req_valid, req_ready          request handshake
//   req_we, req_addr, req_wdata   store/load selector, word address, store data
//   req_rd                        load destination register tag
//   resp_valid, resp_ready        response handshake
//   resp_data, resp_rd, resp_err  load data, echoed tag, out-of-range flag
//  Modports: master = EX/writeback side, slave = sequencer side.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [2:0]        req_rd;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [2:0]        resp_rd;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_rd, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_rd, resp_ready,
        output req_ready, resp_valid, resp_data, resp_rd, resp_err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//  Load/store sequencer between the EX stage and a 16-bit data memory.
//  Accepts one request at a time, drives registered memory port pins,
//  range-checks the address and returns load data over a response channel.
//  Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   bus               request/response channels (mem_access_ctrl_if.slave)
//   err_pulse         one-cycle pulse for any out-of-range request
//   mem_access_addr   registered memory address
//   mem_write_data    registered store data
//   mem_write_en      registered memory write strobe (STORE state only)
//   mem_read          registered memory read strobe (LOAD state only)
//   mem_read_data     combinational read data from memory
//   load_cnt, store_cnt, err_cnt  saturating statistics counters
module mem_access_ctrl #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_ctrl_if.slave     bus,
    output logic                 err_pulse,
    output logic [ADDR_W-1:0]    mem_access_addr,
    output logic [DATA_W-1:0]    mem_write_data,
    output logic                 mem_write_en,
    output logic                 mem_read,
    input  logic [DATA_W-1:0]    mem_read_data,
    output logic [CNT_W-1:0]     load_cnt,
    output logic [CNT_W-1:0]     store_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] STORE = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [ADDR_W-1:0] DEPTH_LIMIT = ADDR_W'(MEM_DEPTH);

    logic [1:0] state;
    logic       in_range;

    assign in_range       = (bus.req_addr < DEPTH_LIMIT);
    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == RESP);

    // Strobes default low each cycle so they are high only in the state that
    // owns them; address and write data are only loaded on an in-range accept
    // and otherwise hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            err_pulse       <= 1'b0;
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
            bus.resp_data   <= '0;
            bus.resp_rd     <= '0;
            bus.resp_err    <= 1'b0;
            load_cnt        <= '0;
            store_cnt       <= '0;
            err_cnt         <= '0;
        end else begin
            err_pulse    <= 1'b0;
            mem_write_en <= 1'b0;
            mem_read     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (in_range) begin
                            mem_access_addr <= bus.req_addr;
                            if (bus.req_we) begin
                                mem_write_data <= bus.req_wdata;
                                mem_write_en   <= 1'b1;
                                state          <= STORE;
                            end else begin
                                mem_read    <= 1'b1;
                                bus.resp_rd <= bus.req_rd;
                                state       <= LOAD;
                            end
                        end else begin
                            // Out-of-range: never touch memory. A bad load
                            // still owes writeback a response, flagged as error.
                            err_pulse <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                            if (bus.req_we) begin
                                state <= IDLE;
                            end else begin
                                bus.resp_data <= '0;
                                bus.resp_err  <= 1'b1;
                                bus.resp_rd   <= bus.req_rd;
                                state         <= RESP;
                            end
                        end
                    end
                end
                STORE: begin
                    if (store_cnt != '1) store_cnt <= store_cnt + 1'b1;
                    state <= IDLE;
                end
                LOAD: begin
                    // Memory read is combinational, so data is valid while
                    // mem_read is high and is captured at the end of LOAD.
                    bus.resp_data <= mem_read_data;
                    bus.resp_err  <= 1'b0;
                    if (load_cnt != '1) load_cnt <= load_cnt + 1'b1;
                    state <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//  Directed self-checking bench for mem_access_ctrl with an 8-word
//  behavioural data memory (combinational read, write on rising edge).
//  Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_access_ctrl;
    logic        clk;
    logic        rst_n;
    logic        err_pulse;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;
    logic [7:0]  load_cnt;
    logic [7:0]  store_cnt;
    logic [7:0]  err_cnt;
    logic [15:0] mem [8];

    int checks = 0;
    int errors = 0;

    mem_access_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(8), .CNT_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_if),
        .err_pulse       (err_pulse),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read        (mem_read),
        .mem_read_data   (mem_read_data),
        .load_cnt        (load_cnt),
        .store_cnt       (store_cnt),
        .err_cnt         (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write_en && mem_access_addr < 16'd8)
            mem[mem_access_addr[2:0]] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_access_addr[2:0]];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic we, input logic [15:0] addr,
                                  input logic [15:0] wdata, input logic [2:0] rd);
        bus_if.req_valid = valid;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        bus_if.req_rd    = rd;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.resp_ready = 1'b1;
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        tick();
        tick();
        check_output("reset_write_en", mem_write_en, 0);
        check_output("reset_read", mem_read, 0);
        check_output("reset_addr", mem_access_addr, 0);
        check_output("reset_resp_valid", bus_if.resp_valid, 0);
        check_output("reset_req_ready", bus_if.req_ready, 1);
        check_output("reset_counters", {load_cnt, store_cnt, err_cnt}, 0);
        rst_n = 1'b1;
        tick();

        // Store 0xBEEF to address 3
        apply_stimulus(1'b1, 1'b1, 16'd3, 16'hBEEF, 3'd0);
        check_output("t1_accept_ready", bus_if.req_ready, 1);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t1_write_en", mem_write_en, 1);
        check_output("t1_addr", mem_access_addr, 16'd3);
        check_output("t1_wdata", mem_write_data, 16'hBEEF);
        check_output("t1_no_read", mem_read, 0);
        check_output("t1_busy", bus_if.req_ready, 0);
        tick();
        check_output("t1_ready_again", bus_if.req_ready, 1);
        check_output("t1_write_en_low", mem_write_en, 0);
        check_output("t1_mem3", mem[3], 16'hBEEF);
        check_output("t1_store_cnt", store_cnt, 1);
        check_output("t1_addr_held", mem_access_addr, 16'd3);

        // Load from address 3, tag 5
        apply_stimulus(1'b1, 1'b0, 16'd3, 16'd0, 3'd5);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t2_read", mem_read, 1);
        check_output("t2_no_write", mem_write_en, 0);
        check_output("t2_addr", mem_access_addr, 16'd3);
        check_output("t2_resp_valid_early", bus_if.resp_valid, 0);
        tick();
        check_output("t2_resp_valid", bus_if.resp_valid, 1);
        check_output("t2_resp_data", bus_if.resp_data, 16'hBEEF);
        check_output("t2_resp_rd", bus_if.resp_rd, 5);
        check_output("t2_resp_err", bus_if.resp_err, 0);
        check_output("t2_load_cnt", load_cnt, 1);
        check_output("t2_read_low", mem_read, 0);
        tick();
        check_output("t2_idle", bus_if.req_ready, 1);
        check_output("t2_resp_done", bus_if.resp_valid, 0);

        // Out-of-range load @9 tag 2
        apply_stimulus(1'b1, 1'b0, 16'd9, 16'd0, 3'd2);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t3_no_read", mem_read, 0);
        check_output("t3_err_pulse", err_pulse, 1);
        check_output("t3_resp_valid", bus_if.resp_valid, 1);
        check_output("t3_resp_data", bus_if.resp_data, 0);
        check_output("t3_resp_err", bus_if.resp_err, 1);
        check_output("t3_resp_rd", bus_if.resp_rd, 2);
        check_output("t3_err_cnt", err_cnt, 1);
        check_output("t3_load_cnt", load_cnt, 1);
        tick();
        check_output("t3_pulse_end", err_pulse, 0);
        check_output("t3_idle", bus_if.req_ready, 1);

        // Out-of-range store at the boundary address 8
        apply_stimulus(1'b1, 1'b1, 16'd8, 16'h1111, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t3s_no_write", mem_write_en, 0);
        check_output("t3s_err_pulse", err_pulse, 1);
        check_output("t3s_idle", bus_if.req_ready, 1);
        check_output("t3s_err_cnt", err_cnt, 2);
        check_output("t3s_store_cnt", store_cnt, 1);

        // Backpressure: load @3 with resp_ready low for 5 cycles
        bus_if.resp_ready = 1'b0;
        apply_stimulus(1'b1, 1'b0, 16'd3, 16'd0, 3'd6);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_output("t4_hold_valid", bus_if.resp_valid, 1);
            check_output("t4_hold_data", bus_if.resp_data, 16'hBEEF);
            check_output("t4_hold_rd", bus_if.resp_rd, 6);
            check_output("t4_hold_busy", bus_if.req_ready, 0);
            tick();
        end
        bus_if.resp_ready = 1'b1;
        tick();
        check_output("t4_release_idle", bus_if.req_ready, 1);
        check_output("t4_release_valid", bus_if.resp_valid, 0);
        check_output("t4_load_cnt", load_cnt, 2);

        // Reset during a store of 0x5555 to address 3
        apply_stimulus(1'b1, 1'b1, 16'd3, 16'h5555, 3'd0);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t5_write_en", mem_write_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_write_en_drop", mem_write_en, 0);
        check_output("t5_addr_clr", mem_access_addr, 0);
        check_output("t5_wdata_clr", mem_write_data, 0);
        check_output("t5_cnt_clr", {load_cnt, store_cnt, err_cnt}, 0);
        tick();
        check_output("t5_mem_unchanged", mem[3], 16'hBEEF);
        rst_n = 1'b1;
        tick();

        // 300 in-range stores: counter saturates at 255
        for (int i = 0; i < 300; i++) begin
            apply_stimulus(1'b1, 1'b1, 16'(i % 8), 16'(i), 3'd0);
            tick();
            apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
            tick();
            if (i == 253) check_output("t6_cnt_254", store_cnt, 254);
            if (i == 254) check_output("t6_cnt_255", store_cnt, 255);
        end
        check_output("t6_cnt_sat", store_cnt, 255);

        // Load after store sees the new data: @3 last got 299, @7 got 295
        apply_stimulus(1'b1, 1'b0, 16'd3, 16'd0, 3'd1);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        tick();
        check_output("t7_load3", bus_if.resp_data, 16'd299);
        tick();
        apply_stimulus(1'b1, 1'b0, 16'd7, 16'd0, 3'd7);
        tick();
        apply_stimulus(1'b0, 1'b0, 16'd0, 16'd0, 3'd0);
        check_output("t7_edge_read", mem_read, 1);
        tick();
        check_output("t7_load7", bus_if.resp_data, 16'd295);
        check_output("t7_load7_rd", bus_if.resp_rd, 7);
        check_output("t7_load_cnt", load_cnt, 2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
